// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the icache and dcache.
// One transaction in flight: grant, issue AR, collect R beats into a 256-bit line, pulse ret_valid.
module cache_rd_arbiter #(
  parameter logic [3:0] ID_IC = 4'd0,
  parameter logic [3:0] ID_DC = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,

  input  logic         ic_rd_req,
  input  logic         ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic [255:0] ic_ret_data,

  input  logic         dc_rd_req,
  input  logic         dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic [255:0] dc_ret_data,

  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,

  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RET} state_t;

  state_t         state_q, state_d;
  logic           last_dc_q, last_dc_d;
  logic           owner_dc_q, owner_dc_d;
  logic           type_q, type_d;
  logic [31:0]    addr_q, addr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [255:0]   buf_q, buf_d;
  logic           gnt_ic, gnt_dc;
  logic           unused_r;

  // rid/rresp carry no information we act on
  assign unused_r = ^{rid, rresp};

  always_comb begin
    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    if (resetn && state_q == S_IDLE) begin
      if (ic_rd_req && dc_rd_req) begin
        gnt_dc = ~last_dc_q;
        gnt_ic = last_dc_q;
      end else begin
        gnt_ic = ic_rd_req;
        gnt_dc = dc_rd_req;
      end
    end
  end

  assign ic_rd_rdy = gnt_ic;
  assign dc_rd_rdy = gnt_dc;

  always_comb begin
    state_d    = state_q;
    last_dc_d  = last_dc_q;
    owner_dc_d = owner_dc_q;
    type_d     = type_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_ic || gnt_dc) begin
          owner_dc_d = gnt_dc;
          last_dc_d  = gnt_dc;
          type_d     = gnt_dc ? dc_rd_type : ic_rd_type;
          addr_d     = gnt_dc ? dc_rd_addr : ic_rd_addr;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          cnt_d = 3'd0;
          // uncached words return zero-extended, so scrub the stale line above word 0
          if (!type_q) buf_d[255:32] = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          buf_d[{cnt_q, 5'b0} +: 32] = rdata;
          cnt_d = cnt_q + 3'd1;
          if (rlast) state_d = S_RET;
        end
      end
      S_RET: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      last_dc_q  <= 1'b0;
      owner_dc_q <= 1'b0;
      cnt_q      <= 3'd0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dc_q  <= last_dc_d;
      owner_dc_q <= owner_dc_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
    end
  end

  always_ff @(posedge clk) begin
    type_q <= type_d;
    addr_q <= addr_d;
  end

  always_comb begin
    arvalid = 1'b0;
    arid    = 4'd0;
    araddr  = 32'd0;
    arlen   = 8'd0;
    arsize  = 3'd0;
    arburst = 2'd0;
    if (state_q == S_AR) begin
      arvalid = 1'b1;
      arid    = owner_dc_q ? ID_DC : ID_IC;
      araddr  = type_q ? {addr_q[31:5], 5'b0} : addr_q;
      arlen   = type_q ? 8'd7 : 8'd0;
      arsize  = 3'b010;
      arburst = 2'b01;
    end
  end

  assign rready       = (state_q == S_R);
  assign ic_ret_valid = (state_q == S_RET) && !owner_dc_q;
  assign dc_ret_valid = (state_q == S_RET) && owner_dc_q;
  assign ic_ret_data  = buf_q;
  assign dc_ret_data  = buf_q;

endmodule
